// File: rtl/fifo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl_if
// Write-side signal bundle for the async-FIFO write controller.
//   W_INC       producer write request
//   WQ2_RPTR    Gray read pointer, synchronized into the write clock domain
//   CLR_OVF     clears the sticky overflow flag
//   W_EN        memory write enable
//   W_ADDR      memory write address
//   W_PTR       registered Gray write pointer for the read-side synchronizer
//   FULL        registered full flag
//   ALMOST_FULL registered almost-full flag
//   W_LEVEL     registered write-side occupancy, 0..DEPTH
//   OVERFLOW    sticky write-while-full flag
// master: producer / surrounding logic; slave: fifo_wr_ctrl.
// ---------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    localparam int PW = ADDR_WIDTH + 1;

    logic                  W_INC;
    logic [PW-1:0]         WQ2_RPTR;
    logic                  CLR_OVF;
    logic                  W_EN;
    logic [ADDR_WIDTH-1:0] W_ADDR;
    logic [PW-1:0]         W_PTR;
    logic                  FULL;
    logic                  ALMOST_FULL;
    logic [PW-1:0]         W_LEVEL;
    logic                  OVERFLOW;

    modport master (
        output W_INC, WQ2_RPTR, CLR_OVF,
        input  W_EN, W_ADDR, W_PTR, FULL, ALMOST_FULL, W_LEVEL, OVERFLOW
    );

    modport slave (
        input  W_INC, WQ2_RPTR, CLR_OVF,
        output W_EN, W_ADDR, W_PTR, FULL, ALMOST_FULL, W_LEVEL, OVERFLOW
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-domain pointer/flag controller of an asynchronous FIFO.
// Keeps the binary write pointer, publishes its Gray form, and derives FULL,
// ALMOST_FULL, W_LEVEL and a sticky OVERFLOW from the synchronized Gray read
// pointer. All flags update on the same edge as W_PTR.
//   CLK  write-domain clock (rising edge)
//   RST  asynchronous active-low reset
//   bus  fifo_wr_ctrl_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 1
) (
    input logic           CLK,
    input logic           RST,
    fifo_wr_ctrl_if.slave bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] w_bin;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] level;
    logic [PW-1:0] level_next;
    logic          full;
    logic          full_next;
    logic          almost_full;
    logic          overflow;
    logic          w_en;

    // Gated by RST so nothing is written while reset is held, even though
    // FULL already reads 0 during reset.
    assign w_en = bus.W_INC & ~full & RST;

    always_comb begin
        w_bin_next  = w_bin + PW'(w_en);
        w_gray_next = w_bin_next ^ (w_bin_next >> 1);

        // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
        r_bin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            r_bin[i] = ^(bus.WQ2_RPTR >> i);
        end

        level_next = w_bin_next - r_bin;
        full_next  = (w_gray_next == {~bus.WQ2_RPTR[PW-1:PW-2], bus.WQ2_RPTR[PW-3:0]});
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            w_bin       <= '0;
            w_gray      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
            overflow    <= 1'b0;
        end else begin
            w_bin       <= w_bin_next;
            w_gray      <= w_gray_next;
            full        <= full_next;
            almost_full <= (level_next >= AF_LEVEL);
            level       <= level_next;
            overflow    <= (bus.W_INC & full) | (overflow & ~bus.CLR_OVF);
        end
    end

    assign bus.W_EN        = w_en;
    assign bus.W_ADDR      = w_bin[ADDR_WIDTH-1:0];
    assign bus.W_PTR       = w_gray;
    assign bus.FULL        = full;
    assign bus.ALMOST_FULL = almost_full;
    assign bus.W_LEVEL     = level;
    assign bus.OVERFLOW    = overflow;
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, memory address width; FIFO depth DEPTH = 2**ADDR_WIDTH (8).
REQ-002 Parameter AF_MARGIN, default 1, free-slot threshold for ALMOST_FULL.
REQ-003 Pointer width PW = ADDR_WIDTH+1 (4), derived and not overridable.
REQ-004 CLK  input  1  write-domain clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low.
REQ-006 W_INC  input  1  write request from producer, sampled on the CLK rising edge.
REQ-007 WQ2_RPTR  input  PW  Gray read pointer, already double-flop synchronized into CLK domain.
REQ-008 CLR_OVF  input  1  clears sticky OVERFLOW.
REQ-009 W_EN  output  1  memory write enable, combinational = W_INC & ~FULL.
REQ-010 W_ADDR  output  ADDR_WIDTH  memory write address = low ADDR_WIDTH bits of binary write pointer.
REQ-011 W_PTR  output  PW  registered Gray write pointer, sent to read-domain synchronizer.
REQ-012 FULL  output  1  registered full flag.
REQ-013 ALMOST_FULL  output  1  registered, asserted when level >= DEPTH-AF_MARGIN.
REQ-014 W_LEVEL  output  PW  registered write-side occupancy, 0..DEPTH.
REQ-015 OVERFLOW  output  1  sticky flag, set by a write attempt while FULL.

Function
REQ-016 Internal binary pointer w_bin (PW bits); w_bin_next = w_bin+1 mod 2**PW when W_EN, else w_bin.
REQ-017 W_PTR registered value = bin2gray(w_bin_next): g = b ^ (b>>1); exactly one bit changes per increment.
REQ-018 FULL next = (bin2gray(w_bin_next) == {~WQ2_RPTR[PW-1:PW-2], WQ2_RPTR[PW-3:0]}).
REQ-019 r_bin = gray2bin(WQ2_RPTR), computed combinationally: b[PW-1]=g[PW-1], b[i]=b[i+1]^g[i].
REQ-020 W_LEVEL next = (w_bin_next - r_bin) mod 2**PW; ALMOST_FULL next derived from the same value.
REQ-021 FULL, W_LEVEL, ALMOST_FULL update in the same edge as W_PTR; no extra latency.
REQ-022 Write accepted only when W_INC=1 and FULL=0; W_INC while FULL leaves w_bin, W_PTR and W_ADDR unchanged.
REQ-023 OVERFLOW next = (W_INC & FULL) | (OVERFLOW & ~CLR_OVF); set wins when it coincides with CLR_OVF.
REQ-024 Pointer wrap: w_bin 15 -> 0 and W_PTR 1000 -> 0000 with no flag glitch; W_ADDR wraps 7 -> 0.
REQ-025 Read-pointer advance (WQ2_RPTR change) deasserts FULL on the next edge, even with no write.
REQ-026 Simultaneous accepted write and read-pointer advance: level unchanged, FULL evaluated against the new WQ2_RPTR.
REQ-027 W_LEVEL is pessimistic (read pointer lags 2+ cycles); it SHALL never under-report occupancy.
REQ-028 WQ2_RPTR values not reachable from a legal read sequence are not checked; behaviour is defined only by REQ-018/020 arithmetic.

Reset
REQ-029 RST low asynchronously forces w_bin=0, W_PTR=0, FULL=0, ALMOST_FULL=0, W_LEVEL=0, OVERFLOW=0.
REQ-030 W_EN is 0 while RST is low regardless of W_INC; W_ADDR=0.
REQ-031 Reset asserted mid-burst discards all pointer state; first edge after release with W_INC=1 writes address 0.
REQ-032 Reset release is synchronous to CLK by system design; no internal reset synchronizer.

Verification
REQ-033 Reset: RST=0 with W_INC=1, WQ2_RPTR=0 -> all outputs 0, W_EN=0; release, one write -> W_PTR=0001, W_ADDR=1, W_LEVEL=1.
REQ-034 Fill: WQ2_RPTR=0000, 8 consecutive writes -> after 7th ALMOST_FULL=1, W_LEVEL=7; after 8th FULL=1, W_PTR=1100, W_LEVEL=8.
REQ-035 Overflow: FULL=1, W_INC=1 for 2 cycles -> W_EN=0, W_PTR stays 1100, OVERFLOW=1; CLR_OVF pulse with W_INC=0 -> OVERFLOW=0.
REQ-036 Drain: from full, WQ2_RPTR=0001 -> next edge FULL=0, ALMOST_FULL=1, W_LEVEL=7; one write -> FULL=1, W_PTR=1101.
REQ-037 Wrap: 20 writes with WQ2_RPTR tracking gray(w_bin-2) -> W_PTR passes 1000 -> 0000, W_ADDR 7 -> 0, FULL never set, W_LEVEL=2 steady.
REQ-038 Simultaneous: level 8 FULL, W_INC=1 and WQ2_RPTR advances one step same cycle -> write rejected this edge, FULL=0 next edge, write accepted following edge, FULL=1 again.
